cis_usb_packetizer: RTL and testbench
=====================================

// Module: cis_usb_packetizer
// PURPOSE
//  Consumes the 8-bit ADC pixel stream produced by the CIS timing generator and
//  streams it to the FT232H-style synchronous FIFO on the USB IC. Buffers samples
//  in an internal FIFO, prefixes each scan line with a 4-byte header, honours
//  USB_TXE_L backpressure, and flags any lost data. Sits between the CIS/ADC
//  timing generator and the USB IC pins.
// PARAMETERS
//  FIFO_DEPTH    512    byte entries in the elastic buffer (power of two)
//  PIX_PER_LINE  2700   pixels accepted per line after the header (300 DPI)
//  SYNC0         8'hA5  first header byte
//  SYNC1         8'h5A  second header byte
// PORTS
//  USB_CLK     in   1   60 MHz USB clock; the only clock
//  RST         in   1   synchronous, active-high reset
//  PIX_VALID   in   1   one-cycle strobe: PIX_DATA holds a valid ADC sample
//  PIX_DATA    in   8   ADC sample
//  LINE_START  in   1   one-cycle pulse, USB_CLK domain, at each CIS_SP
//  USB_TXE_L   in   1   low = USB IC can accept a byte this edge
//  USB_DATA    out  8   byte to the USB IC, registered
//  USB_WR_L    out  1   low = USB_DATA is valid, registered
//  OVERFLOW    out  1   sticky: at least one byte was dropped
//  LINE_COUNT  out  16  number of LINE_STARTs seen since reset
// BEHAVIOUR
//  Reset: USB_WR_L=1, USB_DATA=0, OVERFLOW=0, LINE_COUNT=0, FIFO empty,
//   pending register empty, write FSM in IDLE. Reset asserted mid-line or
//   mid-transfer discards all buffered data.
//  Write FSM: IDLE -> HDR0 -> HDR1 -> HDR2 -> HDR3 -> PIX -> IDLE.
//   IDLE: PIX_VALID ignored; no push, no overflow.
//   LINE_START from any state: latch hdr_cnt=LINE_COUNT, LINE_COUNT<=LINE_COUNT+1
//    (wraps 16'hFFFF->0), clear pending, enter HDR0. A truncated previous line
//    is not padded.
//   HDR0..HDR3: push SYNC0, SYNC1, hdr_cnt[15:8], hdr_cnt[7:0], one per cycle.
//   PIX: push each PIX_VALID byte; after PIX_PER_LINE pushes return to IDLE.
//  Pixel during HDRx: store in 1-entry pending register; push it on the first
//   cycle of PIX, ahead of any new sample; it counts toward PIX_PER_LINE. A
//   second pixel while pending is full: drop it, set OVERFLOW.
//  Push with FIFO full: drop the byte, set OVERFLOW, still advance the FSM and
//   the pixel count. OVERFLOW clears only on RST.
//  Read side: 1-byte output register out_valid/out_data; USB_WR_L = ~out_valid.
//   Transfer happens on an edge where USB_WR_L==0 and USB_TXE_L==0.
//   No transfer while out_valid: hold USB_DATA and USB_WR_L unchanged.
//   Load from FIFO when (!out_valid | transfer) & FIFO non-empty; otherwise
//    out_valid<=0 after a transfer.
//   Latency: a pushed byte reaches USB_DATA 2 cycles after the push when the FIFO
//    was empty and USB_TXE_L is low. Throughput: 1 byte/cycle.
//  Simultaneous push and pop on a full FIFO: the pop frees the slot in the same
//   cycle, so the push succeeds and no overflow is flagged. Push and pop on an
//   empty FIFO do not bypass it.
//  Byte order on USB matches push order; no reordering, no duplication.
// STRUCTURE
//  Shared package cis_pkg: FSM state encoding, SYNC0/SYNC1, CIS_CLK_PER_LINE,
//   and the DPI-dependent PIX_PER_LINE values.
//  Sub-module sync_fifo (#WIDTH=8, DEPTH=FIFO_DEPTH): single-clock, synchronous
//   RST, full/empty flags, pointers one bit wider than the address.
//  Top level holds the write FSM, the pending register, the output register and
//   OVERFLOW.
// TESTING
//  1 Reset, then LINE_START, 2700 PIX_VALID every 6 cycles, TXE_L=0 -> USB stream
//    A5 5A 00 00 followed by the 2700 samples in order; OVERFLOW=0; LINE_COUNT=1.
//  2 PIX_VALID 2 cycles after LINE_START -> that sample appears immediately after
//    the header; a second sample 1 cycle later -> dropped, OVERFLOW=1.
//  3 TXE_L=1 for 600 cycles during a line with FIFO_DEPTH=512 -> USB_WR_L low and
//    USB_DATA frozen; bytes beyond 512+1 dropped; OVERFLOW=1; after TXE_L=0 the
//    surviving bytes drain in order.
//  4 TXE_L toggling every cycle -> each byte appears exactly once and only on
//    edges with WR_L=0 and TXE_L=0.
//  5 LINE_START after 100 pixels -> header A5 5A 00 01 follows pixel 100;
//    LINE_COUNT=2. Preload LINE_COUNT=FFFF -> header bytes FF FF, then count=0000.
//  6 RST asserted mid-drain -> next edge: USB_WR_L=1, OVERFLOW=0, LINE_COUNT=0;
//    no stale bytes appear after reset.

Source files
------------

// File: rtl/cis_usb_packetizer_pkg.sv
// Shared definitions for the CIS-to-USB packetizer: write FSM encoding,
// header sync bytes, line geometry and a small state helper.
package cis_usb_packetizer_pkg;

  localparam int          FIFO_DEPTH_DEF   = 512;
  localparam logic [7:0]  SYNC0            = 8'hA5;
  localparam logic [7:0]  SYNC1            = 8'h5A;

  // CIS clocks per scan line (active pixels plus dark/dummy and SP overhead).
  localparam int          CIS_CLK_PER_LINE = 2760;

  // Active pixels per line for each supported resolution.
  localparam int          PIX_PER_LINE_300 = 2700;
  localparam int          PIX_PER_LINE_600 = 5400;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_HDR2 = 3'd3,
    ST_HDR3 = 3'd4,
    ST_PIX  = 3'd5
  } state_t;

  // True while the FSM is emitting one of the four header bytes.
  function automatic logic is_hdr(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_HDR2) || (s == ST_HDR3);
  endfunction

endpackage

// File: rtl/cis_usb_packetizer_if.sv
// Pixel-side and USB-side signals of the packetizer, plus the FSM state for
// observation.
//
// Handshake: PIX_VALID and LINE_START are single-cycle strobes with no
// backpressure (the packetizer drops and flags what it cannot hold). On the
// USB side a byte moves on every rising edge where USB_WR_L==0 and
// USB_TXE_L==0; while USB_WR_L==0 and USB_TXE_L==1 the packetizer holds
// USB_DATA and USB_WR_L steady.
interface cis_usb_packetizer_if;
  import cis_usb_packetizer_pkg::*;

  logic        PIX_VALID;
  logic [7:0]  PIX_DATA;
  logic        LINE_START;
  logic        USB_TXE_L;
  logic [7:0]  USB_DATA;
  logic        USB_WR_L;
  logic        OVERFLOW;
  logic [15:0] LINE_COUNT;
  state_t      state;

  modport slave (
    input  PIX_VALID, PIX_DATA, LINE_START, USB_TXE_L,
    output USB_DATA, USB_WR_L, OVERFLOW, LINE_COUNT, state
  );

  modport master (
    output PIX_VALID, PIX_DATA, LINE_START, USB_TXE_L,
    input  USB_DATA, USB_WR_L, OVERFLOW, LINE_COUNT, state
  );

endinterface

// File: rtl/cis_usb_packetizer_sync_fifo.sv
// Single-clock elastic buffer. Pointers carry one extra wrap bit so full and
// empty are distinguished without a counter. Read data is the head entry,
// available combinationally; the caller only asserts wr_en when there is room
// (full with a same-cycle pop counts as room).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pointer update; reset empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cis_usb_packetizer.sv
// CIS/ADC pixel stream to FT232H-style synchronous FIFO. Each LINE_START emits
// a 4-byte header (SYNC0, SYNC1, line number MSB, LSB) followed by
// PIX_PER_LINE pixels; bytes pass through an elastic FIFO and a one-byte
// output register that honours USB_TXE_L. Anything that cannot be stored is
// dropped and OVERFLOW is latched.
module cis_usb_packetizer
  import cis_usb_packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int PIX_PER_LINE = PIX_PER_LINE_300
) (
  input  logic USB_CLK,
  input  logic RST,
  cis_usb_packetizer_if.slave bus
);

  localparam logic [15:0] LAST_PIX = 16'(PIX_PER_LINE - 1);

  state_t      state, state_nxt;
  logic [15:0] line_count;
  logic [15:0] hdr_cnt;
  logic [15:0] pix_cnt;
  logic        pend_valid, pend_valid_nxt;
  logic [7:0]  pend_data,  pend_data_nxt;
  logic        push_req;
  logic [7:0]  push_data;
  logic        pix_drop;
  logic        pix_cnt_inc;
  logic        last_pix;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rd_data;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        transfer;
  logic        overflow;

  assign last_pix  = (pix_cnt == LAST_PIX);
  assign transfer  = out_valid && !bus.USB_TXE_L;
  assign fifo_pop  = (!out_valid || transfer) && !fifo_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for this push.
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  // Next state, push request and pending-register update. LINE_START wins
  // over everything: the interrupted line pushes nothing more and a pixel
  // arriving in the same cycle belongs to no line.
  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_data_nxt  = pend_data;
    push_req       = 1'b0;
    push_data      = '0;
    pix_drop       = 1'b0;
    pix_cnt_inc    = 1'b0;
    if (bus.LINE_START) begin
      state_nxt      = ST_HDR0;
      pend_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_HDR0: begin
          push_req  = 1'b1;
          push_data = SYNC0;
          state_nxt = ST_HDR1;
        end
        ST_HDR1: begin
          push_req  = 1'b1;
          push_data = SYNC1;
          state_nxt = ST_HDR2;
        end
        ST_HDR2: begin
          push_req  = 1'b1;
          push_data = hdr_cnt[15:8];
          state_nxt = ST_HDR3;
        end
        ST_HDR3: begin
          push_req  = 1'b1;
          push_data = hdr_cnt[7:0];
          state_nxt = ST_PIX;
        end
        ST_PIX: begin
          if (pend_valid) begin
            // Held pixel goes first; a new sample takes its place unless
            // the held one completes the line.
            push_req       = 1'b1;
            push_data      = pend_data;
            pend_valid_nxt = bus.PIX_VALID && !last_pix;
            if (bus.PIX_VALID) pend_data_nxt = bus.PIX_DATA;
          end else if (bus.PIX_VALID) begin
            push_req  = 1'b1;
            push_data = bus.PIX_DATA;
          end
          if (push_req) begin
            pix_cnt_inc = 1'b1;
            if (last_pix) state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      // Pixels arriving during the header wait in the single pending slot.
      if (is_hdr(state) && bus.PIX_VALID) begin
        if (pend_valid) begin
          pix_drop = 1'b1;
        end else begin
          pend_valid_nxt = 1'b1;
          pend_data_nxt  = bus.PIX_DATA;
        end
      end
    end
  end

  // FSM state, pending slot, line numbering and per-line pixel count.
  always_ff @(posedge USB_CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      line_count <= '0;
      hdr_cnt    <= '0;
      pix_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_data  <= pend_data_nxt;
      if (bus.LINE_START) begin
        hdr_cnt    <= line_count;
        line_count <= line_count + 16'd1;
        pix_cnt    <= '0;
      end else if (pix_cnt_inc) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
    end
  end

  // Sticky loss flag: pending slot already occupied, or FIFO had no room.
  always_ff @(posedge USB_CLK) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (pix_drop || (push_req && !fifo_push)) begin
      overflow <= 1'b1;
    end
  end

  // Output register: refill from the FIFO when empty or just transferred,
  // otherwise hold while the USB IC is not ready.
  always_ff @(posedge USB_CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fifo_pop) begin
      out_valid <= 1'b1;
      out_data  <= fifo_rd_data;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (USB_CLK),
    .rst     (RST),
    .wr_en   (fifo_push),
    .wr_data (push_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.USB_DATA   = out_data;
  assign bus.USB_WR_L   = ~out_valid;
  assign bus.OVERFLOW   = overflow;
  assign bus.LINE_COUNT = line_count;
  assign bus.state      = state;

endmodule

// File: tb/tb_cis_usb_packetizer.sv
// Directed bench for cis_usb_packetizer: full line, header-time pixels,
// long stall with overflow, toggling TXE_L, truncated lines and line-number
// wrap, reset during drain. A negedge monitor pops the expected byte queue on
// every USB transfer and checks that stalled outputs hold.
module tb_cis_usb_packetizer;
  import cis_usb_packetizer_pkg::*;

  logic USB_CLK = 1'b0;
  logic RST;

  always #8 USB_CLK = ~USB_CLK;

  cis_usb_packetizer_if bus();

  cis_usb_packetizer #(
    .FIFO_DEPTH   (512),
    .PIX_PER_LINE (2700)
  ) dut (
    .USB_CLK (USB_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rx_count = 0;
  int          keep_left;
  logic [15:0] model_cnt;
  bit          toggle_txe = 1'b0;
  bit          prev_hold  = 1'b0;
  logic [7:0]  prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge USB_CLK);
    #1;
    if (toggle_txe) bus.USB_TXE_L = ~bus.USB_TXE_L;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    exp_q.delete();
    model_cnt = 16'h0000;
    keep_left = 1 << 30;
  endtask

  // ---------------- driver tasks ----------------
  // Only the first keep_left bytes of a stalled stream can survive.
  task automatic expect_byte(input logic [7:0] b);
    if (keep_left > 0) begin
      exp_q.push_back(b);
      keep_left--;
    end
  endtask

  task automatic expect_header();
    expect_byte(8'hA5);
    expect_byte(8'h5A);
    expect_byte(model_cnt[15:8]);
    expect_byte(model_cnt[7:0]);
    model_cnt = model_cnt + 16'd1;
  endtask

  // LINE_START pulse, then wait out the header so the next drive lands in PIX.
  task automatic start_line();
    bus.LINE_START = 1'b1;
    tick();
    bus.LINE_START = 1'b0;
    expect_header();
    repeat (4) tick();
  endtask

  task automatic send_pix(input logic [7:0] d, input int gap, input bit expected);
    bus.PIX_VALID = 1'b1;
    bus.PIX_DATA  = d;
    tick();
    bus.PIX_VALID = 1'b0;
    if (expected) expect_byte(d);
    repeat (gap) tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    repeat (8) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wr_l"},       bus.USB_WR_L,   1);
    check_eq({tag, "_usb_data"},   bus.USB_DATA,   0);
    check_eq({tag, "_overflow"},   bus.OVERFLOW,   0);
    check_eq({tag, "_line_count"}, bus.LINE_COUNT, 0);
    check_eq({tag, "_state"},      bus.state,      ST_IDLE);
  endtask

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'(i * 7 + seed);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  // Inputs only change just after posedge, so the negedge view is what the
  // next rising edge will act on.
  always @(negedge USB_CLK) begin
    if (prev_hold) begin
      check_eq("hold_wr_l", bus.USB_WR_L, 0);
      check_eq("hold_data", bus.USB_DATA, prev_data);
    end
    prev_hold = !RST && (bus.USB_WR_L === 1'b0) && (bus.USB_TXE_L === 1'b1);
    prev_data = bus.USB_DATA;
    if (bus.USB_WR_L === 1'b0 && bus.USB_TXE_L === 1'b0) begin
      rx_count++;
      check_eq("xfer_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("usb_data", bus.USB_DATA, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rx_start;
    RST            = 1'b1;
    bus.PIX_VALID  = 1'b0;
    bus.PIX_DATA   = 8'h00;
    bus.LINE_START = 1'b0;
    bus.USB_TXE_L  = 1'b0;
    keep_left      = 1 << 30;
    model_cnt      = 16'h0000;

    do_reset();
    check_reset_state("reset");

    // 1: full line, pixel every 6 cycles, USB always ready.
    rx_start = rx_count;
    start_line();
    for (int i = 0; i < 2700; i++) send_pix(pat(i, 3), 5, 1'b1);
    for (int i = 0; i < 3; i++) send_pix(8'hEE, 2, 1'b0);
    wait_drain("t1", 200);
    check_eq("t1_bytes",      rx_count - rx_start, 2704);
    check_eq("t1_overflow",   bus.OVERFLOW,        0);
    check_eq("t1_line_count", bus.LINE_COUNT,      model_cnt);
    check_eq("t1_state",      bus.state,           ST_IDLE);

    // 2: pixel during header is held and emitted first; a second one is lost.
    do_reset();
    bus.LINE_START = 1'b1;
    tick();
    bus.LINE_START = 1'b0;
    expect_header();
    tick();
    send_pix(8'h11, 0, 1'b1);
    send_pix(8'h22, 0, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) send_pix(pat(i, 40), 1, 1'b1);
    wait_drain("t2", 100);
    check_eq("t2_overflow",   bus.OVERFLOW,   1);
    check_eq("t2_line_count", bus.LINE_COUNT, model_cnt);

    // 3: USB stalled ~600 cycles; only FIFO_DEPTH+1 bytes survive.
    do_reset();
    bus.USB_TXE_L = 1'b1;
    keep_left = 513;
    start_line();
    for (int i = 0; i < 595; i++) send_pix(pat(i, 9), 0, 1'b1);
    check_eq("t3_overflow",    bus.OVERFLOW, 1);
    check_eq("t3_wr_l_frozen", bus.USB_WR_L, 0);
    check_eq("t3_data_frozen", bus.USB_DATA, 8'hA5);
    rx_start = rx_count;
    bus.USB_TXE_L = 1'b0;
    wait_drain("t3", 700);
    check_eq("t3_bytes", rx_count - rx_start, 513);

    // 4: TXE_L toggling every cycle.
    do_reset();
    toggle_txe = 1'b1;
    start_line();
    for (int i = 0; i < 40; i++) send_pix(pat(i, 77), 0, 1'b1);
    wait_drain("t4", 200);
    toggle_txe = 1'b0;
    bus.USB_TXE_L = 1'b0;
    check_eq("t4_overflow", bus.OVERFLOW, 0);

    // 5: truncated line, then line-number wrap through 16'hFFFF.
    do_reset();
    start_line();
    for (int i = 0; i < 100; i++) send_pix(pat(i, 5), 0, 1'b1);
    start_line();
    for (int i = 0; i < 5; i++) send_pix(pat(i, 200), 0, 1'b1);
    wait_drain("t5a", 100);
    check_eq("t5_line_count_2", bus.LINE_COUNT, model_cnt);
    // Back-to-back starts emit nothing until the last one settles.
    bus.LINE_START = 1'b1;
    repeat (65533) tick();
    model_cnt = model_cnt + 16'd65533;
    check_eq("t5_line_count_ffff", bus.LINE_COUNT, model_cnt);
    start_line();
    wait_drain("t5b", 50);
    check_eq("t5_line_count_wrap", bus.LINE_COUNT, model_cnt);
    start_line();
    wait_drain("t5c", 50);
    check_eq("t5_line_count_1", bus.LINE_COUNT, model_cnt);

    // 6: reset while draining an overflowed line.
    do_reset();
    bus.USB_TXE_L = 1'b1;
    keep_left = 513;
    start_line();
    for (int i = 0; i < 530; i++) send_pix(pat(i, 60), 0, 1'b1);
    check_eq("t6_overflow_before", bus.OVERFLOW, 1);
    bus.USB_TXE_L = 1'b0;
    repeat (20) tick();
    RST = 1'b1;
    tick();
    check_reset_state("t6_reset");
    RST = 1'b0;
    exp_q.delete();
    keep_left = 1 << 30;
    model_cnt = 16'h0000;
    for (int i = 0; i < 4; i++) send_pix(8'h99, 1, 1'b0);
    repeat (40) tick();
    check_eq("t6_state",     bus.state,    ST_IDLE);
    check_eq("t6_wr_l_idle", bus.USB_WR_L, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
